// File: rtl/bcd_clock_if.sv
// Load/date-time bundle for bcd_clock: DCF77 load strobe and fields in, BCD calendar out.
// Each BCD field is two packed digits, [1] = tens, [0] = units.
interface bcd_clock_if;
  logic            load;
  logic [7:0]      ld_minute;
  logic [7:0]      ld_hour;
  logic [7:0]      ld_day;
  logic [2:0]      ld_dow;
  logic [7:0]      ld_month;
  logic [7:0]      ld_year;

  logic [1:0][3:0] second;
  logic [1:0][3:0] minute;
  logic [1:0][3:0] hour;
  logic [1:0][3:0] day;
  logic [1:0][3:0] month;
  logic [1:0][3:0] year;
  logic [2:0]      day_of_week;
  logic            synced;
  logic            load_err;

  modport master (
    output load, ld_minute, ld_hour, ld_day, ld_dow, ld_month, ld_year,
    input  second, minute, hour, day, month, year, day_of_week, synced, load_err
  );

  modport slave (
    input  load, ld_minute, ld_hour, ld_day, ld_dow, ld_month, ld_year,
    output second, minute, hour, day, month, year, day_of_week, synced, load_err
  );
endinterface

// File: rtl/bcd_clock.sv
// BCD time-of-day/calendar clock with DCF77 load. Optional macro BCD_CLOCK_LOAD_CHECK_EN
// range-checks loads, drops bad ones and pulses load_err.
module bcd_clock #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input logic        clk,
  input logic        reset,
  bcd_clock_if.slave bus
);

  localparam int unsigned PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PMax = PW'(CLK_FREQ - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic [7:0]    day_q, day_d, mon_q, mon_d, year_q, year_d;
  logic [2:0]    dow_q, dow_d;
  logic          synced_q, synced_d, load_err_q, load_err_d;

  logic          tick, leap, ld_ok, accept;
  logic          c_sec, c_min, c_hour, c_day, c_mon;
  logic [7:0]    day_max;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  always_comb begin
    // Odd tens: 12, 16; even tens: 00, 04, 08 (years divisible by four).
    if (year_q[4]) leap = (year_q[3:0] == 4'd2) || (year_q[3:0] == 4'd6);
    else           leap = (year_q[3:0] == 4'd0) || (year_q[3:0] == 4'd4) ||
                          (year_q[3:0] == 4'd8);
    case (mon_q)
      8'h04, 8'h06, 8'h09, 8'h11: day_max = 8'h30;
      8'h02:                      day_max = leap ? 8'h29 : 8'h28;
      default:                    day_max = 8'h31;
    endcase
  end

  always_comb begin
`ifdef BCD_CLOCK_LOAD_CHECK_EN
    ld_ok = bcd_ok(bus.ld_minute) && bcd_ok(bus.ld_hour) && bcd_ok(bus.ld_day) &&
            bcd_ok(bus.ld_month) && bcd_ok(bus.ld_year) &&
            (bus.ld_minute <= 8'h59) && (bus.ld_hour <= 8'h23) &&
            (bus.ld_day >= 8'h01) && (bus.ld_day <= 8'h31) &&
            (bus.ld_month >= 8'h01) && (bus.ld_month <= 8'h12) &&
            (bus.ld_dow != 3'd0);
`else
    ld_ok = 1'b1;
`endif
    accept     = bus.load && ld_ok;
    load_err_d = bus.load && !ld_ok;
  end

  always_comb begin
    tick    = (presc_q == PMax);
    c_sec   = tick && (sec_q == 8'h59);
    c_min   = c_sec && (min_q == 8'h59);
    c_hour  = c_min && (hour_q == 8'h23);
    c_day   = c_hour && (day_q == day_max);
    c_mon   = c_day && (mon_q == 8'h12);

    presc_d  = tick ? '0 : presc_q + PW'(1);
    sec_d    = sec_q;
    min_d    = min_q;
    hour_d   = hour_q;
    day_d    = day_q;
    mon_d    = mon_q;
    year_d   = year_q;
    dow_d    = dow_q;
    synced_d = synced_q;

    if (tick)   sec_d  = c_sec  ? 8'h00 : bcd_inc(sec_q);
    if (c_sec)  min_d  = c_min  ? 8'h00 : bcd_inc(min_q);
    if (c_min)  hour_d = c_hour ? 8'h00 : bcd_inc(hour_q);
    if (c_hour) begin
      day_d = c_day ? 8'h01 : bcd_inc(day_q);
      // Zero means "unknown weekday" and is held until a load supplies one.
      if (dow_q == 3'd7)      dow_d = 3'd1;
      else if (dow_q != 3'd0) dow_d = dow_q + 3'd1;
    end
    if (c_day)  mon_d  = c_mon ? 8'h01 : bcd_inc(mon_q);
    if (c_mon)  year_d = (year_q == 8'h99) ? 8'h00 : bcd_inc(year_q);

    if (accept) begin
      presc_d  = '0;
      sec_d    = 8'h00;
      min_d    = bus.ld_minute;
      hour_d   = bus.ld_hour;
      day_d    = bus.ld_day;
      mon_d    = bus.ld_month;
      year_d   = bus.ld_year;
      dow_d    = bus.ld_dow;
      synced_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      sec_q      <= 8'h00;
      min_q      <= 8'h00;
      hour_q     <= 8'h00;
      day_q      <= 8'h01;
      mon_q      <= 8'h01;
      year_q     <= 8'h00;
      dow_q      <= 3'd0;
      synced_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      day_q      <= day_d;
      mon_q      <= mon_d;
      year_q     <= year_d;
      dow_q      <= dow_d;
      synced_q   <= synced_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.second      = sec_q;
  assign bus.minute      = min_q;
  assign bus.hour        = hour_q;
  assign bus.day         = day_q;
  assign bus.month       = mon_q;
  assign bus.year        = year_q;
  assign bus.day_of_week = dow_q;
  assign bus.synced      = synced_q;
  assign bus.load_err    = load_err_q;

endmodule

// File: tb/tb_bcd_clock.sv
// Scoreboard bench for bcd_clock at CLK_FREQ=4: expected states queued at stimulus time,
// popped and compared when the DUT is sampled (#1 after the rising edge).
module tb_bcd_clock;

  localparam int unsigned ClkFreq = 4;

  logic clk = 1'b0;
  logic reset;

  bcd_clock_if bus ();

  bcd_clock #(.CLK_FREQ(ClkFreq)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] sec, min, hour, day, mon, year;
    logic [2:0] dow;
    logic       synced, err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [7:0] sec, input logic [7:0] min,
                          input logic [7:0] hour, input logic [7:0] day, input logic [7:0] mon,
                          input logic [7:0] year, input logic [2:0] dow, input logic synced,
                          input logic err);
    exp_t e;
    e.tag = tag; e.sec = sec; e.min = min; e.hour = hour; e.day = day; e.mon = mon;
    e.year = year; e.dow = dow; e.synced = synced; e.err = err;
    sb_q.push_back(e);
  endtask

  task automatic compare_state();
    exp_t e;
    check_eq("sb_depth", sb_q.size(), 1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    check_eq({e.tag, ".sec"},    bus.second,      e.sec);
    check_eq({e.tag, ".min"},    bus.minute,      e.min);
    check_eq({e.tag, ".hour"},   bus.hour,        e.hour);
    check_eq({e.tag, ".day"},    bus.day,         e.day);
    check_eq({e.tag, ".month"},  bus.month,       e.mon);
    check_eq({e.tag, ".year"},   bus.year,        e.year);
    check_eq({e.tag, ".dow"},    bus.day_of_week, e.dow);
    check_eq({e.tag, ".synced"}, bus.synced,      e.synced);
    check_eq({e.tag, ".lderr"},  bus.load_err,    e.err);
  endtask

  task automatic drive_ld(input logic [7:0] min, input logic [7:0] hour, input logic [7:0] day,
                          input logic [2:0] dow, input logic [7:0] mon, input logic [7:0] year);
    bus.load      = 1'b1;
    bus.ld_minute = min;
    bus.ld_hour   = hour;
    bus.ld_day    = day;
    bus.ld_dow    = dow;
    bus.ld_month  = mon;
    bus.ld_year   = year;
  endtask

  task automatic do_load(input logic [7:0] min, input logic [7:0] hour, input logic [7:0] day,
                         input logic [2:0] dow, input logic [7:0] mon, input logic [7:0] year);
    drive_ld(min, hour, day, dow, mon, year);
    step(1);
    bus.load = 1'b0;
  endtask

  // Load hh:59 then let exactly one minute (60 ticks) elapse.
  task automatic minute_rollover(input string tag, input logic [7:0] day, input logic [2:0] dow,
                                 input logic [7:0] mon, input logic [7:0] year,
                                 input logic [7:0] e_day, input logic [2:0] e_dow,
                                 input logic [7:0] e_mon, input logic [7:0] e_year);
    do_load(8'h59, 8'h23, day, dow, mon, year);
    push_exp(tag, 8'h00, 8'h00, 8'h00, e_day, e_mon, e_year, e_dow, 1'b1, 1'b0);
    step(60 * ClkFreq);
    compare_state();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.load = 1'b0;
    bus.ld_minute = '0; bus.ld_hour = '0; bus.ld_day = '0;
    bus.ld_dow = '0; bus.ld_month = '0; bus.ld_year = '0;
    step(2);
    reset = 1'b0;

    push_exp("rst", 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0);
    compare_state();
    push_exp("pre_tick", 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0);
    step(3);
    compare_state();
    push_exp("tick1", 8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0);
    step(1);
    compare_state();

    // New Year rollover.
    do_load(8'h59, 8'h23, 8'h31, 3'd7, 8'h12, 8'h99);
    push_exp("ld_ny", 8'h00, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99, 3'd7, 1'b1, 1'b0);
    compare_state();
    push_exp("ny_m1", 8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99, 3'd7, 1'b1, 1'b0);
    step(60 * ClkFreq - 1);
    compare_state();
    push_exp("ny", 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 3'd1, 1'b1, 1'b0);
    step(1);
    compare_state();

    // February and month-length boundaries.
    minute_rollover("feb24", 8'h28, 3'd3, 8'h02, 8'h24, 8'h29, 3'd4, 8'h02, 8'h24);
    minute_rollover("feb23", 8'h28, 3'd3, 8'h02, 8'h23, 8'h01, 3'd4, 8'h03, 8'h23);
    minute_rollover("feb00", 8'h28, 3'd1, 8'h02, 8'h00, 8'h29, 3'd2, 8'h02, 8'h00);
    minute_rollover("feb12", 8'h28, 3'd6, 8'h02, 8'h12, 8'h29, 3'd7, 8'h02, 8'h12);
    minute_rollover("feb10", 8'h28, 3'd6, 8'h02, 8'h10, 8'h01, 3'd7, 8'h03, 8'h10);
    minute_rollover("feb29", 8'h29, 3'd2, 8'h02, 8'h24, 8'h01, 3'd3, 8'h03, 8'h24);
    minute_rollover("apr30", 8'h30, 3'd5, 8'h04, 8'h24, 8'h01, 3'd6, 8'h05, 8'h24);
    minute_rollover("jul31", 8'h30, 3'd5, 8'h07, 8'h24, 8'h31, 3'd6, 8'h07, 8'h24);

    // Load on the prescaler wrap cycle wins over the tick.
    do_load(8'h00, 8'h10, 8'h15, 3'd2, 8'h06, 8'h24);
    step(ClkFreq - 1);
    drive_ld(8'h12, 8'h10, 8'h15, 3'd2, 8'h06, 8'h24);
    push_exp("ld_wrap", 8'h00, 8'h12, 8'h10, 8'h15, 8'h06, 8'h24, 3'd2, 1'b1, 1'b0);
    step(1);
    bus.load = 1'b0;
    compare_state();
    push_exp("wrap_hold", 8'h00, 8'h12, 8'h10, 8'h15, 8'h06, 8'h24, 3'd2, 1'b1, 1'b0);
    step(ClkFreq - 1);
    compare_state();
    push_exp("wrap_tick", 8'h01, 8'h12, 8'h10, 8'h15, 8'h06, 8'h24, 3'd2, 1'b1, 1'b0);
    step(1);
    compare_state();

    // Back-to-back loads: last one wins.
    drive_ld(8'h11, 8'h01, 8'h02, 3'd3, 8'h03, 8'h04);
    step(1);
    drive_ld(8'h45, 8'h17, 8'h09, 3'd5, 8'h11, 8'h37);
    push_exp("b2b", 8'h00, 8'h45, 8'h17, 8'h09, 8'h11, 8'h37, 3'd5, 1'b1, 1'b0);
    step(1);
    bus.load = 1'b0;
    compare_state();

    // Out-of-range hour.
    do_load(8'h30, 8'h08, 8'h10, 3'd3, 8'h05, 8'h24);
    step(1);
    drive_ld(8'h30, 8'h24, 8'h10, 3'd3, 8'h05, 8'h24);
`ifdef BCD_CLOCK_LOAD_CHECK_EN
    push_exp("bad_hr", 8'h00, 8'h30, 8'h08, 8'h10, 8'h05, 8'h24, 3'd3, 1'b1, 1'b1);
    step(1);
    bus.load = 1'b0;
    compare_state();
    push_exp("bad_hr2", 8'h00, 8'h30, 8'h08, 8'h10, 8'h05, 8'h24, 3'd3, 1'b1, 1'b0);
`else
    push_exp("hr24", 8'h00, 8'h30, 8'h24, 8'h10, 8'h05, 8'h24, 3'd3, 1'b1, 1'b0);
    step(1);
    bus.load = 1'b0;
    compare_state();
    push_exp("hr24_2", 8'h00, 8'h30, 8'h24, 8'h10, 8'h05, 8'h24, 3'd3, 1'b1, 1'b0);
`endif
    step(1);
    compare_state();

    // Reset asserted mid-count together with a load.
    step(2);
    drive_ld(8'h22, 8'h22, 8'h22, 3'd4, 8'h10, 8'h55);
    reset = 1'b1;
    #1;
    push_exp("rst_async", 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0);
    compare_state();
    step(1);
    reset = 1'b0;
    bus.load = 1'b0;
    push_exp("rst_rel", 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0);
    compare_state();
    push_exp("rst_tick", 8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0);
    step(ClkFreq);
    compare_state();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
